rtype_inst_encoder: RTL

//  Encoder/issuer on the instruction side of the single-cycle core: accepts decoded
//  R-type fields (rs, rt, rd, func) from a test/program source, validates func,

---
 rtl/rtype_pkg.sv | 44 ++++
 rtl/rtype_inst_encoder_fifo.sv | 58 +++++
 rtl/rtype_inst_encoder.sv | 69 ++++++
 3 files changed

// File: rtl/rtype_pkg.sv
// Shared R-type encoding constants and helpers for the instruction-side encoder.
package rtype_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNC_W  = 6;

    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned FUNC_LSB = 0;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] FUNC_ADD = 6'd32;
    localparam logic [5:0] FUNC_SUB = 6'd34;
    localparam logic [5:0] FUNC_AND = 6'd36;
    localparam logic [5:0] FUNC_OR  = 6'd37;
    localparam logic [5:0] FUNC_SLT = 6'd42;

    // Only the ALU operations the core actually implements are legal.
    function automatic logic is_legal_func(input logic [FUNC_W-1:0] func);
        logic legal;
        legal = 1'b0;
        case (func)
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_SLT: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Shamt field is left at zero by construction.
    function automatic logic [INST_W-1:0] encode_rtype(input logic [REG_W-1:0]  rs,
                                                       input logic [REG_W-1:0]  rt,
                                                       input logic [REG_W-1:0]  rd,
                                                       input logic [FUNC_W-1:0] func);
        return (INST_W'(OP_RTYPE) << OP_LSB) |
               (INST_W'(rs)       << RS_LSB) |
               (INST_W'(rt)       << RT_LSB) |
               (INST_W'(rd)       << RD_LSB) |
               (INST_W'(func)     << FUNC_LSB);
    endfunction

endpackage

// File: rtl/rtype_inst_encoder_fifo.sv
// Circular instruction buffer with occupancy count; head entry reads as zero when empty.
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy state; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rtype_inst_encoder.sv
// Packs R-type fields into MIPS words, drops unsupported funcs, and issues buffered words to the core.
module rtype_inst_encoder
    import rtype_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_func,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic              reject,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  reject_cnt
);

    logic        legal_c;
    logic        accept_c;
    logic        push_c;
    logic        pop_c;
    logic        full;
    logic        empty;
    logic [31:0] word_c;

    assign legal_c   = is_legal_func(in_func);
    assign word_c    = encode_rtype(in_rs, in_rt, in_rd, in_func);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept_c  = in_valid && in_ready;
    assign push_c    = accept_c && legal_c && !flush;
    assign pop_c     = out_valid && out_ready && !flush;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (word_c),
        .rdata (out_inst),
        .full  (full),
        .empty (empty)
    );

    // Illegal funcs still complete the handshake; flush does not hide the rejection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject     <= 1'b0;
            reject_cnt <= '0;
            issued_cnt <= '0;
        end else begin
            reject <= accept_c && !legal_c;
            if (accept_c && !legal_c) reject_cnt <= reject_cnt + CNT_W'(1);
            if (pop_c)                issued_cnt <= issued_cnt + CNT_W'(1);
        end
    end

endmodule
